// File: rtl/coeff_loader_if.sv
// Coefficient word stream into coeff_loader: valid/ready handshake with an end-of-set marker.
interface coeff_loader_if #(
  parameter int TAP_WIDTH = 32
) ();
  logic                        cfg_valid;
  logic                        cfg_ready;
  logic signed [TAP_WIDTH-1:0] cfg_data;
  logic                        cfg_last;

  modport master (
    output cfg_valid,
    output cfg_data,
    output cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    input  cfg_last,
    output cfg_ready
  );
endinterface

// File: rtl/coeff_loader.sv
// Runtime IIR coefficient writer: fills a shadow bank, swaps it into the active bank on a sample strobe.
// Optional feature: define COEFF_RANGE_CHECK_EN to reject words outside the signed 16-bit range.
module coeff_loader #(
  parameter int TAP_WIDTH    = 32,
  parameter int FF_TAP_COUNT = 4,
  parameter int FB_TAP_COUNT = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  coeff_loader_if.slave                          i_cfg,
  input  logic                                   i_sample_strobe,
  output logic [FF_TAP_COUNT-1:0][TAP_WIDTH-1:0] o_B,
  output logic [FB_TAP_COUNT-1:0][TAP_WIDTH-1:0] o_A,
  output logic                                   o_load_pending,
  output logic                                   o_coeff_updated,
  output logic                                   o_load_err
);

  localparam int N     = FF_TAP_COUNT + FB_TAP_COUNT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  state_t                                 r_state;
  state_t                                 w_nextState;
  logic [CNT_W-1:0]                       r_wordCount;
  logic [N-1:0][TAP_WIDTH-1:0]            r_shadow;
  logic [FF_TAP_COUNT-1:0][TAP_WIDTH-1:0] r_B;
  logic [FB_TAP_COUNT-1:0][TAP_WIDTH-1:0] r_A;
  logic                                   r_coeffUpdated;
  logic                                   r_loadErr;

  logic w_accept;
  logic w_ready;
  logic w_rangeBad;
  logic w_abort;
  logic w_cntInc;
  logic w_cntClr;
  logic w_commit;

  // Power-up coefficient set, used until the first successful runtime load.
  function automatic logic [TAP_WIDTH-1:0] resetTapB(input int idx);
    case (idx)
      0:       return TAP_WIDTH'(2);
      1:       return TAP_WIDTH'(6);
      2:       return TAP_WIDTH'(6);
      3:       return TAP_WIDTH'(2);
      default: return '0;
    endcase
  endfunction

  function automatic logic [TAP_WIDTH-1:0] resetTapA(input int idx);
    case (idx)
      0:       return TAP_WIDTH'(-22432);
      1:       return TAP_WIDTH'(20560);
      2:       return TAP_WIDTH'(-6303);
      default: return '0;
    endcase
  endfunction

`ifdef COEFF_RANGE_CHECK_EN
  // In range exactly when bit 15 and everything above it is a pure sign extension.
  logic [TAP_WIDTH-16:0] w_upper;
  assign w_upper    = i_cfg.cfg_data[TAP_WIDTH-1:15];
  assign w_rangeBad = !((&w_upper) || !(|w_upper));
`else
  assign w_rangeBad = 1'b0;
`endif

  assign w_accept        = i_cfg.cfg_valid && w_ready;
  assign i_cfg.cfg_ready = w_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = (w_rangeBad || i_cfg.cfg_last) ? IDLE : LOAD;
        end
      end
      LOAD: begin
        if (w_accept) begin
          if (w_rangeBad) begin
            w_nextState = IDLE;
          end else if (r_wordCount == LAST_IDX) begin
            w_nextState = i_cfg.cfg_last ? PEND : IDLE;
          end else if (i_cfg.cfg_last) begin
            w_nextState = IDLE;
          end
        end
      end
      PEND: begin
        if (i_sample_strobe) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Range faults take priority over framing faults; a strobe outside PEND is ignored.
  always_comb begin
    w_ready        = 1'b1;
    w_abort        = 1'b0;
    w_cntInc       = 1'b0;
    w_cntClr       = 1'b0;
    w_commit       = 1'b0;
    o_load_pending = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_rangeBad || i_cfg.cfg_last) begin
            w_abort = 1'b1;
          end else begin
            w_cntInc = 1'b1;
          end
        end
      end
      LOAD: begin
        if (w_accept) begin
          if (w_rangeBad) begin
            w_abort = 1'b1;
          end else if (r_wordCount == LAST_IDX) begin
            w_abort  = !i_cfg.cfg_last;
            w_cntClr = 1'b1;
          end else if (i_cfg.cfg_last) begin
            w_abort = 1'b1;
          end else begin
            w_cntInc = 1'b1;
          end
        end
      end
      PEND: begin
        w_ready        = 1'b0;
        o_load_pending = 1'b1;
        w_commit       = i_sample_strobe;
      end
      default: w_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wordCount <= '0;
      r_shadow    <= '0;
    end else begin
      if (w_accept) begin
        r_shadow[r_wordCount] <= i_cfg.cfg_data;
      end
      if (w_cntClr || w_abort) begin
        r_wordCount <= '0;
      end else if (w_cntInc) begin
        r_wordCount <= r_wordCount + CNT_W'(1);
      end
    end
  end

  // The active bank only moves on commit, so the filter never sees a partial set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FF_TAP_COUNT; i++) begin
        r_B[i] <= resetTapB(i);
      end
      for (int i = 0; i < FB_TAP_COUNT; i++) begin
        r_A[i] <= resetTapA(i);
      end
      r_coeffUpdated <= 1'b0;
      r_loadErr      <= 1'b0;
    end else begin
      r_coeffUpdated <= w_commit;
      r_loadErr      <= w_abort;
      if (w_commit) begin
        r_B <= r_shadow[FF_TAP_COUNT-1:0];
        r_A <= r_shadow[N-1:FF_TAP_COUNT];
      end
    end
  end

  assign o_B             = r_B;
  assign o_A             = r_A;
  assign o_coeff_updated = r_coeffUpdated;
  assign o_load_err      = r_loadErr;

endmodule
